// File: rtl/vend_ctrl_param.sv
// Parametrised vending transaction controller: item select, coin credit,
// price compare, dispense and change/refund, all outputs registered.
module vend_ctrl_param #(
    parameter int  N_ITEMS     = 4,
    parameter int  MONEY_W     = 8,
    parameter int  TIMEOUT_CYC = 16,
    localparam int ITEM_W      = $clog2(N_ITEMS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       item_valid,
    input  logic [ITEM_W-1:0]          item_sel,
    input  logic [N_ITEMS*MONEY_W-1:0] price_table,
    input  logic                       coin_valid,
    input  logic [MONEY_W-1:0]         coin_value,
    input  logic                       cancel,
    output logic                       coin_reject,
    output logic                       dispense,
    output logic                       done,
    output logic                       end_trans,
    output logic [MONEY_W-1:0]         sum_money,
    output logic [MONEY_W-1:0]         price,
    output logic [ITEM_W-1:0]          item_select,
    output logic [MONEY_W-1:0]         change
);

    localparam logic [2:0] S_IDLE          = 3'd0;
    localparam logic [2:0] S_SELECT        = 3'd1;
    localparam logic [2:0] S_RECEIVE_MONEY = 3'd2;
    localparam logic [2:0] S_COMPARE       = 3'd3;
    localparam logic [2:0] S_PROCESS       = 3'd4;
    localparam logic [2:0] S_RETURN_CHANGE = 3'd5;
    localparam logic [2:0] S_REFUND        = 3'd6;

    localparam int               TMO_W      = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ITEM_W:0]  ITEM_LIMIT = (ITEM_W + 1)'(N_ITEMS);

    logic [2:0]         state_q, state_d;
    logic [MONEY_W-1:0] sum_q, sum_d;
    logic [MONEY_W-1:0] price_q, price_d;
    logic [ITEM_W-1:0]  item_q, item_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               coin_reject_q, coin_reject_d;
    logic               dispense_q, dispense_d;
    logic               done_q, done_d;
    logic               end_trans_q, end_trans_d;

    logic [MONEY_W:0]   coin_total;
    logic               coin_fits;
    logic               coin_accept;
    logic               item_ok;
    logic [MONEY_W-1:0] sel_price;

    // The carry bit of the widened sum flags a coin that would wrap the credit.
    assign coin_total = {1'b0, sum_q} + {1'b0, coin_value};
    assign coin_fits  = ~coin_total[MONEY_W];
    assign item_ok    = {1'b0, item_sel} < ITEM_LIMIT;

    always_comb begin
        sel_price = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (ITEM_W'(k) == item_sel) sel_price = price_table[k*MONEY_W +: MONEY_W];
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        state_d     = state_q;
        sum_d       = sum_q;
        price_d     = price_q;
        item_d      = item_q;
        change_d    = change_q;
        tmo_d       = tmo_q;
        coin_accept = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else if (item_valid && item_ok) begin
                    item_d  = item_sel;
                    price_d = sel_price;
                    tmo_d   = '0;
                    state_d = S_RECEIVE_MONEY;
                end
            end
            S_RECEIVE_MONEY: begin
                if (cancel) begin
                    change_d = sum_q;
                    state_d  = S_REFUND;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        sum_d       = coin_total[MONEY_W-1:0];
                        tmo_d       = '0;
                        coin_accept = 1'b1;
                    end else if (tmo_q < TMO_LAST) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    change_d = sum_q;
                    state_d  = S_REFUND;
                end else if (sum_q >= price_q) begin
                    state_d = S_COMPARE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_COMPARE: begin
                change_d = sum_q - price_q;
                state_d  = S_PROCESS;
            end
            S_PROCESS:       state_d = S_RETURN_CHANGE;
            S_RETURN_CHANGE: state_d = S_IDLE;
            S_REFUND:        state_d = S_IDLE;
            default:         state_d = S_IDLE;
        endcase

        // Entering or sitting in IDLE wipes the previous transaction's values.
        if (state_d == S_IDLE) begin
            sum_d    = '0;
            price_d  = '0;
            item_d   = '0;
            change_d = '0;
            tmo_d    = '0;
        end

        coin_reject_d = coin_valid && !coin_accept;
        dispense_d    = (state_d == S_PROCESS);
        done_d        = (state_d == S_RETURN_CHANGE);
        end_trans_d   = (state_d == S_RETURN_CHANGE) || (state_d == S_REFUND);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sum_q         <= '0;
            price_q       <= '0;
            item_q        <= '0;
            change_q      <= '0;
            tmo_q         <= '0;
            coin_reject_q <= 1'b0;
            dispense_q    <= 1'b0;
            done_q        <= 1'b0;
            end_trans_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            price_q       <= price_d;
            item_q        <= item_d;
            change_q      <= change_d;
            tmo_q         <= tmo_d;
            coin_reject_q <= coin_reject_d;
            dispense_q    <= dispense_d;
            done_q        <= done_d;
            end_trans_q   <= end_trans_d;
        end
    end

    assign coin_reject = coin_reject_q;
    assign dispense    = dispense_q;
    assign done        = done_q;
    assign end_trans   = end_trans_q;
    assign sum_money   = sum_q;
    assign price       = price_q;
    assign item_select = item_q;
    assign change      = change_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Randomised scoreboard bench for vend_ctrl_param: stimulus predicts pulse cycles
// and closing values from the sale rules, an independent monitor compares them.
module tb_vend_ctrl_param;

    localparam int N_ITEMS     = 5;
    localparam int MONEY_W     = 8;
    localparam int TIMEOUT_CYC = 16;
    localparam int ITEM_W      = $clog2(N_ITEMS);
    localparam int MAXV        = (1 << MONEY_W) - 1;

    localparam int K_SALE       = 0;
    localparam int K_CANCEL     = 1;
    localparam int K_TIMEOUT    = 2;
    localparam int K_SEL_CANCEL = 3;

    typedef struct {
        int cyc;
        bit done;
        bit sale;
        int change;
        int sum;
        int price;
        int item;
    } end_t;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic                       item_valid;
    logic [ITEM_W-1:0]          item_sel;
    logic [N_ITEMS*MONEY_W-1:0] price_table;
    logic                       coin_valid;
    logic [MONEY_W-1:0]         coin_value;
    logic                       cancel;
    logic                       coin_reject;
    logic                       dispense;
    logic                       done;
    logic                       end_trans;
    logic [MONEY_W-1:0]         sum_money;
    logic [MONEY_W-1:0]         price;
    logic [ITEM_W-1:0]          item_select;
    logic [MONEY_W-1:0]         change;

    vend_ctrl_param #(
        .N_ITEMS    (N_ITEMS),
        .MONEY_W    (MONEY_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .item_valid (item_valid),
        .item_sel   (item_sel),
        .price_table(price_table),
        .coin_valid (coin_valid),
        .coin_value (coin_value),
        .cancel     (cancel),
        .coin_reject(coin_reject),
        .dispense   (dispense),
        .done       (done),
        .end_trans  (end_trans),
        .sum_money  (sum_money),
        .price      (price),
        .item_select(item_select),
        .change     (change)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec = 0;
    int   n_err = 0;
    int   prices[N_ITEMS];
    int   coin_list[$];
    end_t end_q[$];
    int   disp_q[$];
    int   rej_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every output pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (dispense === 1'b1) begin
            if (disp_q.size() == 0) check("dispense_unexpected", dispense, 0);
            else check("dispense_cycle", cyc, disp_q.pop_front());
        end
        if (coin_reject === 1'b1) begin
            if (rej_q.size() == 0) check("coin_reject_unexpected", coin_reject, 0);
            else check("coin_reject_cycle", cyc, rej_q.pop_front());
        end
        if (done === 1'b1) check("done_with_end_trans", end_trans, 1);
        if (end_trans === 1'b1) begin
            if (end_q.size() == 0) begin
                check("end_trans_unexpected", end_trans, 0);
            end else begin
                end_t e;
                e = end_q.pop_front();
                check("end_cycle", cyc, e.cyc);
                check("end_done", done, e.done);
                check("end_change", change, e.change);
                if (e.sale) begin
                    check("end_sum", sum_money, e.sum);
                    check("end_price", price, e.price);
                    check("end_item", item_select, e.item);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_price(input int k, input int v);
        prices[k] = v;
        price_table[k*MONEY_W +: MONEY_W] = MONEY_W'(v);
    endtask

    task automatic gen_coins(input int kind, input int p);
        int s, c, hi;
        bit prev_rej;
        coin_list.delete();
        s = 0;
        prev_rej = 1'b0;
        if (kind == K_SALE) begin
            while (s < p) begin
                if (!prev_rej && s > 0 && $urandom_range(0, 4) == 0) begin
                    c = (MAXV + 1 - s) + int'($urandom_range(0, s - 1));
                    prev_rej = 1'b1;
                end else begin
                    hi = MAXV - s;
                    if (hi > 64) hi = 64;
                    c = int'($urandom_range(1, hi));
                    s += c;
                    prev_rej = 1'b0;
                end
                coin_list.push_back(c);
            end
        end else begin
            repeat ($urandom_range(0, 3)) begin
                if (p - s > 1) begin
                    hi = p - s - 1;
                    if (hi > 64) hi = 64;
                    c = int'($urandom_range(1, hi));
                    s += c;
                    coin_list.push_back(c);
                end
            end
        end
    endtask

    // Drives one transaction from IDLE and predicts its observable outcome.
    task automatic run_trans(input int kind, input int item, input bit bad_sel,
                             input bit cancel_coin, input int cancel_val, input bit late_coin);
        int   sum, p, last, stop;
        end_t e;
        p   = prices[item];
        sum = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (bad_sel) begin
            item_valid = 1'b1;
            item_sel   = ITEM_W'(N_ITEMS + int'($urandom_range(0, (1 << ITEM_W) - N_ITEMS - 1)));
            tick();
            check("bad_sel_item_held", item_select, 0);
        end
        if (kind == K_SEL_CANCEL) begin
            item_valid = 1'b0;
            cancel = 1'b1;
            tick();
            cancel = 1'b0;
            return;
        end
        item_valid = 1'b1;
        item_sel   = ITEM_W'(item);
        tick();
        item_valid = 1'b0;
        last = cyc;
        for (int i = 0; i < coin_list.size(); i++) begin
            if (kind == K_SALE && sum >= p) break;
            repeat ($urandom_range(0, 3)) begin
                start = ($urandom_range(0, 3) == 0);
                tick();
                start = 1'b0;
            end
            coin_valid = 1'b1;
            coin_value = MONEY_W'(coin_list[i]);
            tick();
            coin_valid = 1'b0;
            if (sum + coin_list[i] > MAXV) begin
                rej_q.push_back(cyc);
            end else begin
                sum += coin_list[i];
                last = cyc;
            end
        end
        e.sum   = sum;
        e.price = p;
        e.item  = item;
        if (kind == K_SALE) begin
            disp_q.push_back(last + 2);
            e.cyc = last + 3; e.done = 1'b1; e.sale = 1'b1; e.change = sum - p;
            end_q.push_back(e);
            tick();
            if (late_coin) begin
                repeat ($urandom_range(0, 2)) tick();
                coin_valid = 1'b1;
                coin_value = MONEY_W'($urandom_range(1, MAXV));
                tick();
                coin_valid = 1'b0;
                rej_q.push_back(cyc);
            end
            while (cyc < last + 4) tick();
        end else if (kind == K_CANCEL) begin
            repeat ($urandom_range(0, 3)) tick();
            cancel = 1'b1;
            if (cancel_coin) begin
                coin_valid = 1'b1;
                coin_value = MONEY_W'(cancel_val);
            end
            tick();
            cancel = 1'b0;
            coin_valid = 1'b0;
            if (cancel_coin) rej_q.push_back(cyc);
            e.cyc = cyc; e.done = 1'b0; e.sale = 1'b0; e.change = sum;
            end_q.push_back(e);
            tick();
        end else begin
            e.cyc = last + TIMEOUT_CYC; e.done = 1'b0; e.sale = 1'b0; e.change = sum;
            end_q.push_back(e);
            stop = last + TIMEOUT_CYC + 1;
            while (cyc < stop) tick();
        end
    endtask

    initial begin
        int kind, item, r;
        rst_n       = 1'b0;
        start       = 1'b0;
        item_valid  = 1'b0;
        item_sel    = '0;
        price_table = '0;
        coin_valid  = 1'b0;
        coin_value  = '0;
        cancel      = 1'b0;
        for (int k = 0; k < N_ITEMS; k++) set_price(k, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_coin_reject", coin_reject, 0);
        check("reset_dispense", dispense, 0);
        check("reset_done", done, 0);
        check("reset_end_trans", end_trans, 0);
        check("reset_sum", sum_money, 0);
        check("reset_price", price, 0);
        check("reset_item", item_select, 0);
        check("reset_change", change, 0);
        tick();

        // Sale with change.
        set_price(2, 8'h23);
        coin_list = '{8'h10, 8'h10, 8'h0A};
        run_trans(K_SALE, 2, 1'b0, 1'b0, 0, 1'b0);
        // Exact payment.
        set_price(0, 8'h05);
        coin_list = '{8'h05};
        run_trans(K_SALE, 0, 1'b0, 1'b0, 0, 1'b1);
        // Overflowing coin is refused, credit stays, sale completes at full scale.
        set_price(1, 8'hFF);
        coin_list = '{8'hF0, 8'h20, 8'h0F};
        run_trans(K_SALE, 1, 1'b0, 1'b0, 0, 1'b0);
        // Inactivity refund.
        set_price(4, 8'h30);
        coin_list = '{8'h03};
        run_trans(K_TIMEOUT, 4, 1'b0, 1'b0, 0, 1'b0);
        // Cancel with a simultaneous coin.
        set_price(0, 8'h20);
        coin_list = '{8'h08};
        run_trans(K_CANCEL, 0, 1'b0, 1'b1, 8'h04, 1'b0);
        // Invalid selection first, then zero-price item.
        set_price(3, 8'h00);
        coin_list.delete();
        run_trans(K_SALE, 3, 1'b1, 1'b0, 0, 1'b0);

        // Reset while dispensing.
        set_price(3, 8'h05);
        start = 1'b1; tick(); start = 1'b0;
        item_valid = 1'b1; item_sel = ITEM_W'(3); tick(); item_valid = 1'b0;
        coin_valid = 1'b1; coin_value = 8'h05; tick(); coin_valid = 1'b0;
        r = cyc;
        disp_q.push_back(r + 2);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_dispense", dispense, 0);
        check("midrst_done", done, 0);
        check("midrst_end_trans", end_trans, 0);
        check("midrst_sum", sum_money, 0);
        check("midrst_price", price, 0);
        check("midrst_item", item_select, 0);
        check("midrst_change", change, 0);
        tick();

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < N_ITEMS; k++)
                set_price(k, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAXV)));
            item = int'($urandom_range(0, N_ITEMS - 1));
            r = int'($urandom_range(0, 9));
            kind = (r <= 5) ? K_SALE : (r <= 7) ? K_CANCEL : (r == 8) ? K_TIMEOUT : K_SEL_CANCEL;
            if (prices[item] == 0 && (kind == K_CANCEL || kind == K_TIMEOUT)) kind = K_SALE;
            gen_coins(kind, prices[item]);
            run_trans(kind, item, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                      int'($urandom_range(1, MAXV)), $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (4) tick();
        check("pending_end_trans", end_q.size(), 0);
        check("pending_dispense", disp_q.size(), 0);
        check("pending_coin_reject", rej_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
- Parametrised vending transaction controller, successor to the fixed 6-state output decoder.
- Owns the full sequential flow in one block: item select, coin accumulation, price compare, dispense, change/refund.
- Item count, money width and inactivity timeout are configurable.
- Outputs are registered, so no downstream decode is needed.

Parameters:
N_ITEMS, 4, number of selectable items (2..16)
MONEY_W, 8, width of coin, price, sum and change values
TIMEOUT_CYC, 16, idle cycles in RECEIVE_MONEY before automatic refund (>=2)
ITEM_W, $clog2(N_ITEMS), width of item index (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin transaction (sampled in IDLE)
item_valid  input  1  item_sel valid (sampled in SELECT)
item_sel  input  ITEM_W  requested item index
price_table  input  N_ITEMS*MONEY_W  packed prices, item k at [k*MONEY_W +: MONEY_W]
coin_valid  input  1  one coin presented this cycle
coin_value  input  MONEY_W  coin value
cancel  input  1  abort request
coin_reject  output  1  1-cycle pulse, coin not accepted
dispense  output  1  1-cycle pulse, release item_select
done  output  1  1-cycle pulse, successful sale complete
end_trans  output  1  1-cycle pulse, transaction closed (sale or refund)
sum_money  output  MONEY_W  accumulated credit
price  output  MONEY_W  latched price of selected item
item_select  output  ITEM_W  latched item index
change  output  MONEY_W  amount returned, valid while end_trans=1

Behaviour:
- Reset (rst_n=0 at a clock edge) takes effect from any state, mid-transaction included:
  - State goes to IDLE.
  - All outputs and internal counters go to 0; credit is discarded, with no refund pulse.
- States: IDLE=0, SELECT=1, RECEIVE_MONEY=2, COMPARE=3, PROCESS=4, RETURN_CHANGE=5, REFUND=6.
- IDLE:
  - start=1 -> SELECT.
  - sum_money, price, change and item_select are cleared on entry.
- SELECT:
  - item_valid=1 with item_sel<N_ITEMS: latch item_sel and its price -> RECEIVE_MONEY.
  - item_sel>=N_ITEMS: ignored, stay in SELECT.
  - A price of 0 is legal; it still passes through RECEIVE_MONEY.
  - cancel -> IDLE (no credit held).
- RECEIVE_MONEY:
  - coin_valid adds coin_value to sum_money at the next edge.
  - If sum_money+coin_value exceeds 2^MONEY_W-1: coin is not added and coin_reject pulses on the next cycle.
  - Timeout counter reloads to 0 on entry and on every accepted coin, otherwise increments.
  - Timeout reaching TIMEOUT_CYC-1 -> REFUND.
  - cancel -> REFUND.
  - Otherwise, if sum_money>=price -> COMPARE, evaluated on the registered sum after the coin is added.
  - Priority within one cycle: cancel > coin_valid > timeout > compare. A coin arriving with cancel is rejected (coin_reject pulses) and is not added.
- COMPARE (1 cycle):
  - change <= sum_money - price, as an unsigned MONEY_W subtraction; cannot underflow because of the entry condition.
  - Next state PROCESS.
  - Coins in COMPARE, PROCESS and RETURN_CHANGE are rejected with coin_reject.
- PROCESS (1 cycle):
  - dispense=1 for exactly this cycle.
  - Next state RETURN_CHANGE. cancel is ignored from this point.
- RETURN_CHANGE (1 cycle):
  - done=1, end_trans=1.
  - sum_money, price, item_select and change are held for observation.
  - Next state IDLE.
- REFUND (1 cycle):
  - change <= sum_money, end_trans=1, done=0, no dispense.
  - Next state IDLE.
- Latency:
  - Last coin edge to dispense: 2 cycles.
  - Last coin edge to end_trans: 3 cycles.
- coin_reject is a registered pulse, one cycle after the offending coin.
- start outside IDLE is ignored.

Test Plan:
1. Sale with change: price_table item2=0x23, select 2, coins 0x10,0x10,0x0A -> sum 0x2A, dispense 2 cycles after last coin, then done=end_trans=1, change=0x07, item_select=2.
2. Exact pay: price 0x05, single coin 0x05 -> change=0x00, done=1.
3. Overflow reject (MONEY_W=8): sum 0xF0 with price 0xFF, coin 0x20 -> coin_reject pulse, sum stays 0xF0; coin 0x0F -> sum 0xFF, sale proceeds with change 0.
4. Timeout refund (TIMEOUT_CYC=16): select, coin 0x03, then no activity -> REFUND 16 cycles after the coin, end_trans=1, change=0x03, done=0, dispense never asserted.
5. Cancel with simultaneous coin: sum 0x08, cancel=1 and coin 0x04 same cycle -> coin_reject=1, refund change=0x08.
6. Reset mid-PROCESS: rst_n=0 one edge -> all outputs 0 next cycle, state IDLE; invalid item_sel=N_ITEMS in SELECT stays in SELECT.
